// File: rtl/ppu_pixel_compositor.sv
// PPU pixel compositor: double-buffered line data, sprite/background
// priority mux and palette lookup with a fixed two-cycle latency.
module ppu_pixel_compositor (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      hcount,
   input  logic [9:0]       vcount,
   input  logic             line_load,
   input  logic [1279:0]    bg_line,
   input  logic [39:0]      bg_pal,
   input  logic [2:0]       spr_valid,
   input  logic [2:0][9:0]  spr_x,
   input  logic [2:0][31:0] spr_pix,
   input  logic [2:0]       spr_pal,
   input  logic [7:0][23:0] palette_table,
   output logic [7:0]       VGA_R,
   output logic [7:0]       VGA_G,
   output logic [7:0]       VGA_B,
   output logic             pix_valid,
   output logic             shadow_empty,
   output logic             line_overrun
);

   logic [1279:0]    r_sh_bg, r_ac_bg;
   logic [39:0]      r_sh_pal, r_ac_pal;
   logic [2:0]       r_sh_v, r_ac_v;
   logic [2:0][9:0]  r_sh_x, r_ac_x;
   logic [2:0][31:0] r_sh_pix, r_ac_pix;
   logic [2:0]       r_sh_sp, r_ac_sp;
   logic             r_pending;
   logic             r_overrun;

   logic             r_s1_act;
   logic [1:0]       r_s1_bgpix;
   logic             r_s1_bgsel;
   logic [2:0]       r_s1_hit;
   logic [2:0][1:0]  r_s1_spix;
   logic [2:0]       r_s1_sp;

   logic [23:0]      r_rgb;
   logic             r_pix_valid;

   logic             w_swap;
   logic             w_act;
   logic [9:0]       w_x;
   logic [9:0]       w_xc;
   logic [1:0]       w_bgpix;
   logic             w_bgsel;
   logic [2:0]       w_hit;
   logic [2:0][3:0]  w_col;
   logic [2:0][1:0]  w_spix;
   logic [2:0]       w_idx;
   logic [23:0]      w_rgb;

   assign w_swap = (hcount == 11'd0) && r_pending;

   // A coincident load and swap moves the old shadow forward and
   // refills shadow, so the buffer stays pending without an overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh_bg   <= '0;
         r_sh_pal  <= '0;
         r_sh_v    <= '0;
         r_sh_x    <= '0;
         r_sh_pix  <= '0;
         r_sh_sp   <= '0;
         r_ac_bg   <= '0;
         r_ac_pal  <= '0;
         r_ac_v    <= '0;
         r_ac_x    <= '0;
         r_ac_pix  <= '0;
         r_ac_sp   <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_swap) begin
            r_ac_bg  <= r_sh_bg;
            r_ac_pal <= r_sh_pal;
            r_ac_v   <= r_sh_v;
            r_ac_x   <= r_sh_x;
            r_ac_pix <= r_sh_pix;
            r_ac_sp  <= r_sh_sp;
         end
         if (line_load) begin
            r_sh_bg  <= bg_line;
            r_sh_pal <= bg_pal;
            r_sh_v   <= spr_valid;
            r_sh_x   <= spr_x;
            r_sh_pix <= spr_pix;
            r_sh_sp  <= spr_pal;
         end
         if (line_load)
            r_pending <= 1'b1;
         else if (w_swap)
            r_pending <= 1'b0;
         if (line_load && r_pending && !w_swap)
            r_overrun <= 1'b1;
      end
   end

   assign w_x     = hcount[10:1];
   assign w_act   = (hcount < 11'd1280) && (vcount < 10'd480);
   assign w_xc    = w_act ? w_x : 10'd0;
   assign w_bgpix = r_ac_bg[{w_xc, 1'b0} +: 2];
   assign w_bgsel = r_ac_pal[w_xc[9:4]];

   // Hit test at 11 bits so sprites near x=639 clip rather than wrap.
   always_comb begin
      w_hit  = '0;
      w_col  = '0;
      w_spix = '0;
      for (int k = 0; k < 3; k++) begin
         w_hit[k]  = r_ac_v[k]
                   && ({1'b0, w_x} >= {1'b0, r_ac_x[k]})
                   && ({1'b0, w_x} < ({1'b0, r_ac_x[k]} + 11'd16));
         w_col[k]  = w_x[3:0] - r_ac_x[k][3:0];
         w_spix[k] = r_ac_pix[k][{w_col[k], 1'b0} +: 2];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_act   <= 1'b0;
         r_s1_bgpix <= '0;
         r_s1_bgsel <= 1'b0;
         r_s1_hit   <= '0;
         r_s1_spix  <= '0;
         r_s1_sp    <= '0;
      end else begin
         r_s1_act   <= w_act;
         r_s1_bgpix <= w_bgpix;
         r_s1_bgsel <= w_bgsel;
         r_s1_hit   <= w_hit;
         r_s1_spix  <= w_spix;
         r_s1_sp    <= r_ac_sp;
      end
   end

   always_comb begin
      w_idx = {r_s1_bgsel, r_s1_bgpix};
      for (int k = 2; k >= 0; k--) begin
         if (r_s1_hit[k] && (r_s1_spix[k] != 2'b00))
            w_idx = {r_s1_sp[k], r_s1_spix[k]};
      end
      w_rgb = palette_table[w_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rgb       <= '0;
         r_pix_valid <= 1'b0;
      end else begin
         r_rgb       <= r_s1_act ? w_rgb : 24'h0;
         r_pix_valid <= r_s1_act;
      end
   end

   assign VGA_R        = r_rgb[23:16];
   assign VGA_G        = r_rgb[15:8];
   assign VGA_B        = r_rgb[7:0];
   assign pix_valid    = r_pix_valid;
   assign shadow_empty = ~r_pending;
   assign line_overrun = r_overrun;

endmodule

// File: tb/tb_ppu_pixel_compositor.sv
// Scoreboard bench for ppu_pixel_compositor: line-level reference
// model, randomized lines/palettes, and directed corner scenarios.
module tb_ppu_pixel_compositor;

   typedef struct packed {
      logic [1279:0]    bg;
      logic [39:0]      pal;
      logic [2:0]       v;
      logic [2:0][9:0]  x;
      logic [2:0][31:0] pix;
      logic [2:0]       sp;
   } line_t;

   typedef struct packed {
      logic [23:0] rgb;
      logic        vld;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [10:0]     hcount = '0;
   logic [9:0]      vcount = '0;
   logic            line_load = 1'b0;
   line_t           drv = '0;
   logic [7:0][23:0] pal = '0;
   logic [7:0]      VGA_R, VGA_G, VGA_B;
   logic            pix_valid, shadow_empty, line_overrun;

   line_t m_sh = '0;
   line_t m_ac = '0;
   bit    m_pend = 0;
   bit    m_ovr = 0;

   exp_t  q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   logic [2:0] prev_idx = '0;
   bit    prev_act = 0;
   bit    have_prev = 0;

   always #5 clk = ~clk;

   ppu_pixel_compositor dut (
      .clk           (clk),
      .reset         (reset),
      .hcount        (hcount),
      .vcount        (vcount),
      .line_load     (line_load),
      .bg_line       (drv.bg),
      .bg_pal        (drv.pal),
      .spr_valid     (drv.v),
      .spr_x         (drv.x),
      .spr_pix       (drv.pix),
      .spr_pal       (drv.sp),
      .palette_table (pal),
      .VGA_R         (VGA_R),
      .VGA_G         (VGA_G),
      .VGA_B         (VGA_B),
      .pix_valid     (pix_valid),
      .shadow_empty  (shadow_empty),
      .line_overrun  (line_overrun)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at t=%0t", name, act, req, $time);
      end
   endtask

   // Palette index for pixel x of a line, straight from the priority rules.
   function automatic logic [2:0] ref_idx(line_t L, int x);
      for (int k = 0; k < 3; k++) begin
         int sx;
         logic [1:0] p;
         sx = int'(L.x[k]);
         if (L.v[k] && x >= sx && x < sx + 16) begin
            p = L.pix[k][2 * (x - sx) +: 2];
            if (p != 2'b00) return {L.sp[k], p};
         end
      end
      return {L.pal[x / 16], L.bg[2 * x +: 2]};
   endfunction

   function automatic line_t rand_line();
      line_t L;
      for (int i = 0; i < 40; i++) L.bg[32 * i +: 32] = $urandom;
      L.pal = {$urandom, $urandom};
      L.v   = 3'($urandom);
      for (int k = 0; k < 3; k++) begin
         L.x[k]   = 10'($urandom_range(0, 639));
         L.pix[k] = $urandom;
      end
      L.sp = 3'($urandom);
      return L;
   endfunction

   task automatic cyc(int h, int v, bit ld);
      exp_t e;
      bit   act;
      bit   swap;
      hcount    = 11'(h);
      vcount    = 10'(v);
      line_load = ld;
      if (have_prev) begin
         e.rgb = prev_act ? pal[prev_idx] : 24'h0;
         e.vld = prev_act;
         q.push_back(e);
      end
      act       = (h < 1280) && (v < 480);
      prev_act  = act;
      prev_idx  = act ? ref_idx(m_ac, h / 2) : 3'd0;
      have_prev = 1;
      @(posedge clk);
      swap = (h == 0) && m_pend;
      if (ld && m_pend && !swap) m_ovr = 1;
      if (swap) m_ac = m_sh;
      if (ld) begin
         m_sh   = drv;
         m_pend = 1;
      end else if (swap) begin
         m_pend = 0;
      end
      #1;
      check("shadow_empty", shadow_empty, !m_pend);
      check("line_overrun", line_overrun, m_ovr);
   endtask

   task automatic scan(int x0, int x1, int v);
      for (int x = x0; x <= x1; x++) cyc(2 * x + $urandom_range(0, 1), v, 0);
   endtask

   task automatic load_swap(line_t L);
      drv = L;
      cyc(700, 500, 1);
      cyc(0, 500, 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_shadow_empty", shadow_empty, 1);
      check("rst_overrun", line_overrun, 0);
      q.delete();
      have_prev = 0;
      m_pend = 0;
      m_ovr  = 0;
      m_sh   = '0;
      m_ac   = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset && q.size() >= 2) begin
         e = q.pop_front();
         check("rgb", {VGA_R, VGA_G, VGA_B}, e.rgb);
         check("pix_valid", pix_valid, e.vld);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      line_t L;
      line_t L2;
      for (int i = 0; i < 8; i++) pal[i] = 24'($urandom);
      pal[1] = 24'hFF0000;
      pal[6] = 24'h00FF00;
      repeat (3) @(posedge clk);
      #1;
      check("init_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
      check("init_pix_valid", pix_valid, 0);
      check("init_shadow_empty", shadow_empty, 1);
      check("init_overrun", line_overrun, 0);
      reset = 1'b1;

      // No load yet: hcount==0 must not swap anything in.
      repeat (4) cyc(0, 10, 0);

      L = '0;
      for (int i = 0; i < 640; i++) L.bg[2 * i +: 2] = 2'b01;
      load_swap(L);
      cyc(0, 10, 0);
      scan(1, 40, 10);

      L = rand_line();
      L.v      = 3'b011;
      L.x[0]   = 10'd100;
      L.pix[0] = {16{2'b10}};
      L.sp[0]  = 1'b1;
      L.x[1]   = 10'd104;
      L.pix[1] = {16{2'b11}};
      L.sp[1]  = 1'b0;
      load_swap(L);
      scan(90, 125, 20);

      L = rand_line();
      L.v      = 3'b111;
      L.x[0]   = 10'd44;
      L.pix[0] = '0;
      L.x[1]   = 10'd48;
      L.pix[1] = {16{2'b01}};
      L.sp[1]  = 1'b1;
      L.x[2]   = 10'd60;
      L.pix[2] = '0;
      load_swap(L);
      scan(40, 80, 30);

      // Load coinciding with the swap while pending.
      L  = rand_line();
      L2 = rand_line();
      drv = L;
      cyc(300, 500, 1);
      drv = L2;
      cyc(0, 500, 1);
      scan(1, 60, 40);
      cyc(0, 500, 0);
      scan(300, 340, 41);

      // Two loads with no swap between them.
      drv = rand_line();
      cyc(300, 500, 1);
      drv = rand_line();
      cyc(5, 500, 1);
      cyc(0, 500, 0);
      scan(1, 50, 50);
      scan(200, 220, 51);
      reset_pulse();
      repeat (3) cyc(0, 10, 0);

      L = rand_line();
      L.v      = 3'b001;
      L.x[0]   = 10'd630;
      L.pix[0] = $urandom | 32'h55555555;
      load_swap(L);
      scan(615, 639, 100);
      scan(1, 20, 100);
      for (int h = 1278; h < 1290; h++) cyc(h, 100, 0);
      cyc(1265, 480, 0);
      cyc(1262, 479, 0);
      cyc(1270, 700, 0);

      for (int i = 0; i < 800; i++) begin
         int h;
         if ($urandom_range(0, 40) == 0) pal[$urandom_range(0, 7)] = 24'($urandom);
         if ($urandom_range(0, 60) == 0) drv = rand_line();
         h = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(0, 1400);
         cyc(h, $urandom_range(0, 520), $urandom_range(0, 120) == 0);
      end
      repeat (4) cyc(1500, 500, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
